// File: rtl/cardgame21_pkg.sv
//==============================================================================
// Module      : cardgame21_pkg
// Description : Shared encodings, FSM states and default thresholds for the
//               multi-player 21 table and its display logic.
// Revision    : 1.0
//==============================================================================
`default_nettype none

package cardgame21_pkg;

    localparam logic [1:0] c_PENDING = 2'b00;
    localparam logic [1:0] c_WIN     = 2'b01;
    localparam logic [1:0] c_LOSE    = 2'b10;
    localparam logic [1:0] c_PUSH    = 2'b11;

    localparam logic [1:0] c_PHASE_PLAYERS = 2'b00;
    localparam logic [1:0] c_PHASE_DEALER  = 2'b01;
    localparam logic [1:0] c_PHASE_DONE    = 2'b10;

    localparam int c_DEF_TARGET       = 21;
    localparam int c_DEF_DEALER_STAND = 17;
    localparam int c_DEF_CARD_MAX     = 10;

    typedef enum logic [2:0] {
        P_WAIT  = 3'd0,
        P_ADD   = 3'd1,
        P_CHECK = 3'd2,
        D_DRAW  = 3'd3,
        D_ADD   = 3'd4,
        D_CHECK = 3'd5,
        RESOLVE = 3'd6,
        DONE    = 3'd7
    } state_t;

    // RESOLVE still belongs to the dealer phase; only DONE reports completion.
    function automatic logic [1:0] phase_of(input state_t s);
        case (s)
            P_WAIT, P_ADD, P_CHECK:           phase_of = c_PHASE_PLAYERS;
            D_DRAW, D_ADD, D_CHECK, RESOLVE:  phase_of = c_PHASE_DEALER;
            default:                          phase_of = c_PHASE_DONE;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/edge_detect.sv
//==============================================================================
// Module      : edge_detect
// Description : Registers a level input and emits a one-cycle rising-edge pulse.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic r_level_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_level_q <= 1'b0;
        end else begin
            r_level_q <= level;
        end
    end

    assign pulse = level & ~r_level_q;

endmodule

`default_nettype wire

// File: rtl/cardgame21_table.sv
//==============================================================================
// Module      : cardgame21_table
// Description : One round of 21 for N_PLAYERS players against an automatic
//               dealer, with per-player win/lose/push resolution.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module cardgame21_table
    import cardgame21_pkg::*;
#(
    parameter int N_PLAYERS    = 2,
    parameter int SCORE_W      = 6,
    parameter int TARGET       = c_DEF_TARGET,
    parameter int DEALER_STAND = c_DEF_DEALER_STAND,
    parameter int CARD_MAX     = c_DEF_CARD_MAX
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           draw,
    input  logic                           next,
    input  logic [3:0]                     card_in,
    output logic [N_PLAYERS*SCORE_W-1:0]   player_scores,
    output logic [SCORE_W-1:0]             dealer_score,
    output logic [3:0]                     last_card,
    output logic [2:0]                     active_player,
    output logic [1:0]                     phase,
    output logic [2*N_PLAYERS-1:0]         results
);

    localparam logic [SCORE_W-1:0] c_TARGET   = SCORE_W'(TARGET);
    localparam logic [SCORE_W-1:0] c_STAND    = SCORE_W'(DEALER_STAND);
    localparam logic [3:0]         c_CARD_MAX = 4'(CARD_MAX);
    localparam logic [2:0]         c_LAST     = 3'(N_PLAYERS - 1);

    state_t             r_state, w_state_nxt;
    logic [SCORE_W-1:0] r_score  [N_PLAYERS];
    logic [SCORE_W-1:0] w_score_nxt [N_PLAYERS];
    logic [1:0]         r_result [N_PLAYERS];
    logic [1:0]         w_result_nxt [N_PLAYERS];
    logic [SCORE_W-1:0] r_dealer, w_dealer_nxt;
    logic [3:0]         r_last_card, w_last_card_nxt;
    logic [2:0]         r_active, w_active_nxt;
    logic               r_stand, w_stand_nxt;

    logic               w_draw_edge, w_next_edge;
    logic [3:0]         w_card;
    logic [SCORE_W-1:0] w_cur_score;
    logic               w_all_bust;

    edge_detect u_draw_edge (
        .clock (clock),
        .reset (reset),
        .level (draw),
        .pulse (w_draw_edge)
    );

    edge_detect u_next_edge (
        .clock (clock),
        .reset (reset),
        .level (next),
        .pulse (w_next_edge)
    );

    assign w_card = (card_in == 4'd0 || card_in > c_CARD_MAX) ? c_CARD_MAX : card_in;

    // Before RESOLVE, a LOSE result can only mean the player busted.
    always_comb begin
        w_cur_score = '0;
        w_all_bust  = 1'b1;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (r_active == 3'(i)) begin
                w_cur_score = r_score[i];
            end
            if (r_result[i] != c_LOSE) begin
                w_all_bust = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_dealer_nxt    = r_dealer;
        w_last_card_nxt = r_last_card;
        w_active_nxt    = r_active;
        w_stand_nxt     = r_stand;
        for (int i = 0; i < N_PLAYERS; i++) begin
            w_score_nxt[i]  = r_score[i];
            w_result_nxt[i] = r_result[i];
        end

        case (r_state)
            P_WAIT: begin
                if (w_next_edge) begin
                    w_stand_nxt = 1'b1;
                    w_state_nxt = P_CHECK;
                end else if (w_draw_edge) begin
                    w_last_card_nxt = w_card;
                    w_state_nxt     = P_ADD;
                end
            end
            P_ADD: begin
                for (int i = 0; i < N_PLAYERS; i++) begin
                    if (r_active == 3'(i)) begin
                        w_score_nxt[i] = r_score[i] + SCORE_W'(r_last_card);
                    end
                end
                w_state_nxt = P_CHECK;
            end
            P_CHECK: begin
                if (w_cur_score > c_TARGET) begin
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        if (r_active == 3'(i)) begin
                            w_result_nxt[i] = c_LOSE;
                        end
                    end
                end
                if (w_cur_score >= c_TARGET || r_stand) begin
                    w_stand_nxt = 1'b0;
                    if (r_active == c_LAST) begin
                        w_state_nxt = D_DRAW;
                    end else begin
                        w_active_nxt = r_active + 3'd1;
                        w_state_nxt  = P_WAIT;
                    end
                end else begin
                    w_state_nxt = P_WAIT;
                end
            end
            D_DRAW: begin
                if (w_all_bust) begin
                    w_state_nxt = RESOLVE;
                end else if (r_dealer < c_STAND) begin
                    w_last_card_nxt = w_card;
                    w_state_nxt     = D_ADD;
                end else begin
                    w_state_nxt = RESOLVE;
                end
            end
            D_ADD: begin
                w_dealer_nxt = r_dealer + SCORE_W'(r_last_card);
                w_state_nxt  = D_CHECK;
            end
            D_CHECK: begin
                w_state_nxt = D_DRAW;
            end
            RESOLVE: begin
                for (int i = 0; i < N_PLAYERS; i++) begin
                    if (r_result[i] != c_LOSE) begin
                        if (r_dealer > c_TARGET || r_score[i] > r_dealer) begin
                            w_result_nxt[i] = c_WIN;
                        end else if (r_score[i] == r_dealer) begin
                            w_result_nxt[i] = c_PUSH;
                        end else begin
                            w_result_nxt[i] = c_LOSE;
                        end
                    end
                end
                w_state_nxt = DONE;
            end
            DONE: begin
                if (w_draw_edge || w_next_edge) begin
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        w_score_nxt[i]  = '0;
                        w_result_nxt[i] = c_PENDING;
                    end
                    w_dealer_nxt    = '0;
                    w_last_card_nxt = '0;
                    w_active_nxt    = '0;
                    w_stand_nxt     = 1'b0;
                    w_state_nxt     = P_WAIT;
                end
            end
            default: w_state_nxt = P_WAIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= P_WAIT;
            r_dealer    <= '0;
            r_last_card <= '0;
            r_active    <= '0;
            r_stand     <= 1'b0;
            for (int i = 0; i < N_PLAYERS; i++) begin
                r_score[i]  <= '0;
                r_result[i] <= c_PENDING;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_dealer    <= w_dealer_nxt;
            r_last_card <= w_last_card_nxt;
            r_active    <= w_active_nxt;
            r_stand     <= w_stand_nxt;
            for (int i = 0; i < N_PLAYERS; i++) begin
                r_score[i]  <= w_score_nxt[i];
                r_result[i] <= w_result_nxt[i];
            end
        end
    end

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_pack
        assign player_scores[g*SCORE_W +: SCORE_W] = r_score[g];
        assign results[2*g +: 2]                   = r_result[g];
    end

    assign dealer_score  = r_dealer;
    assign last_card     = r_last_card;
    assign active_player = r_active;
    assign phase         = phase_of(r_state);

endmodule

`default_nettype wire

// File: tb/tb_cardgame21_table.sv
//==============================================================================
// Module      : tb_cardgame21_table
// Description : Self-checking bench for cardgame21_table with two players.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_cardgame21_table;

    localparam int NP = 2;
    localparam int SW = 6;

    localparam int SEL_SCORE  = 0;
    localparam int SEL_DEALER = 1;
    localparam int SEL_LAST   = 2;
    localparam int SEL_ACTIVE = 3;
    localparam int SEL_PHASE  = 4;
    localparam int SEL_RESULT = 5;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             draw  = 1'b0;
    logic             next  = 1'b0;
    logic [3:0]       card_in = 4'd0;
    logic [NP*SW-1:0] player_scores;
    logic [SW-1:0]    dealer_score;
    logic [3:0]       last_card;
    logic [2:0]       active_player;
    logic [1:0]       phase;
    logic [2*NP-1:0]  results;

    cardgame21_table #(.N_PLAYERS(NP), .SCORE_W(SW)) dut (
        .clock         (clock),
        .reset         (reset),
        .draw          (draw),
        .next          (next),
        .card_in       (card_in),
        .player_scores (player_scores),
        .dealer_score  (dealer_score),
        .last_card     (last_card),
        .active_player (active_player),
        .phase         (phase),
        .results       (results)
    );

    always #5 clock = ~clock;

    typedef struct {
        string name;
        int    sel;
        int    idx;
        int    val;
    } exp_t;

    typedef struct {
        logic [3:0] card;
        int         exp_card;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[7];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic int actual(input int sel, input int idx);
        case (sel)
            SEL_SCORE:  return int'(player_scores[idx*SW +: SW]);
            SEL_DEALER: return int'(dealer_score);
            SEL_LAST:   return int'(last_card);
            SEL_ACTIVE: return int'(active_player);
            SEL_PHASE:  return int'(phase);
            default:    return int'(results[idx*2 +: 2]);
        endcase
    endfunction

    task automatic expect_val(input string name, input int sel, input int idx, input int val);
        exp_t e;
        e.name = name; e.sel = sel; e.idx = idx; e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check_all();
        exp_t e;
        int   a;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = actual(e.sel, e.idx);
            n_vec++;
            if (a != e.val) begin
                n_fail++;
                $display("FAIL %s: got %0d, expected %0d", e.name, a, e.val);
            end
        end
    endtask

    task automatic expect_cleared(input string tag);
        expect_val({tag, " score0"}, SEL_SCORE, 0, 0);
        expect_val({tag, " score1"}, SEL_SCORE, 1, 0);
        expect_val({tag, " dealer"}, SEL_DEALER, 0, 0);
        expect_val({tag, " last"},   SEL_LAST, 0, 0);
        expect_val({tag, " active"}, SEL_ACTIVE, 0, 0);
        expect_val({tag, " phase"},  SEL_PHASE, 0, 0);
        expect_val({tag, " res0"},   SEL_RESULT, 0, 0);
        expect_val({tag, " res1"},   SEL_RESULT, 1, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; draw = 1'b0; next = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Edge at the following posedge k; returns after k+2 (turn logic settled).
    task automatic press_draw(input logic [3:0] c);
        card_in = c; draw = 1'b1;
        @(negedge clock);
        draw = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic press_next();
        next = 1'b1;
        @(negedge clock);
        next = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    // Last player stands; dealer latches c1 at k+2, c2 at k+5, c3 at k+8.
    task automatic stand_dealer(input logic [3:0] c1, input logic [3:0] c2, input logic [3:0] c3);
        card_in = c1; next = 1'b1;
        @(negedge clock);
        next = 1'b0;
        repeat (2) @(negedge clock);
        card_in = c2;
        repeat (3) @(negedge clock);
        card_in = c3;
        repeat (3) @(negedge clock);
    endtask

    task automatic wait_phase(input logic [1:0] ph, input int budget);
        int cnt = 0;
        while (phase != ph && cnt < budget) begin
            @(negedge clock);
            cnt++;
        end
        n_vec++;
        if (phase != ph) begin
            n_fail++;
            $display("FAIL wait_phase: got %0d, expected %0d within %0d cycles", phase, ph, budget);
        end
    endtask

    initial begin
        vecs[0] = '{4'd0,  10};
        vecs[1] = '{4'd1,  1};
        vecs[2] = '{4'd5,  5};
        vecs[3] = '{4'd9,  9};
        vecs[4] = '{4'd10, 10};
        vecs[5] = '{4'd11, 10};
        vecs[6] = '{4'd15, 10};

        @(negedge clock);
        do_reset();
        expect_cleared("reset");
        check_all();

        // Card legalisation, one draw per fresh round
        for (int i = 0; i < 7; i++) begin
            do_reset();
            press_draw(vecs[i].card);
            expect_val($sformatf("legal last[%0d]", i), SEL_LAST, 0, vecs[i].exp_card);
            expect_val($sformatf("legal score[%0d]", i), SEL_SCORE, 0, vecs[i].exp_card);
            expect_val($sformatf("legal active[%0d]", i), SEL_ACTIVE, 0, 0);
            check_all();
        end

        // Held draw applies exactly one card
        do_reset();
        card_in = 4'd5; draw = 1'b1;
        @(negedge clock);
        @(negedge clock);
        expect_val("hold score k+1", SEL_SCORE, 0, 5);
        check_all();
        repeat (18) @(negedge clock);
        draw = 1'b0;
        expect_val("hold score end", SEL_SCORE, 0, 5);
        expect_val("hold last end", SEL_LAST, 0, 5);
        expect_val("hold active", SEL_ACTIVE, 0, 0);
        check_all();

        // P0 busts, P1 stands on 10, dealer 10+9 = 19
        do_reset();
        press_draw(4'd10); press_draw(4'd10); press_draw(4'd5);
        expect_val("bust score0", SEL_SCORE, 0, 25);
        expect_val("bust res0", SEL_RESULT, 0, 2);
        expect_val("bust active", SEL_ACTIVE, 0, 1);
        expect_val("bust res1 pending", SEL_RESULT, 1, 0);
        check_all();
        press_draw(4'd10);
        stand_dealer(4'd10, 4'd9, 4'd9);
        wait_phase(2'b10, 20);
        expect_val("d19 dealer", SEL_DEALER, 0, 19);
        expect_val("d19 last", SEL_LAST, 0, 9);
        expect_val("d19 res0", SEL_RESULT, 0, 2);
        expect_val("d19 res1", SEL_RESULT, 1, 2);
        check_all();

        // Same players, dealer 10+5+10 busts, P1 wins
        do_reset();
        press_draw(4'd10); press_draw(4'd10); press_draw(4'd5);
        press_draw(4'd10);
        stand_dealer(4'd10, 4'd5, 4'd10);
        wait_phase(2'b10, 20);
        expect_val("dbust dealer", SEL_DEALER, 0, 25);
        expect_val("dbust res0", SEL_RESULT, 0, 2);
        expect_val("dbust res1", SEL_RESULT, 1, 1);
        check_all();

        // P0 20 wins, P1 17 pushes against dealer 17
        do_reset();
        press_draw(4'd10); press_draw(4'd10);
        press_next();
        expect_val("push active", SEL_ACTIVE, 0, 1);
        check_all();
        press_draw(4'd10); press_draw(4'd7);
        stand_dealer(4'd10, 4'd7, 4'd10);
        wait_phase(2'b10, 20);
        expect_val("push dealer", SEL_DEALER, 0, 17);
        expect_val("push score0", SEL_SCORE, 0, 20);
        expect_val("push score1", SEL_SCORE, 1, 17);
        expect_val("push res0", SEL_RESULT, 0, 1);
        expect_val("push res1", SEL_RESULT, 1, 3);
        check_all();

        // Both bust: dealer never draws, then a next edge restarts the round
        do_reset();
        press_draw(4'd10); press_draw(4'd10); press_draw(4'd5);
        card_in = 4'd3;
        press_draw(4'd10); press_draw(4'd10); press_draw(4'd5);
        wait_phase(2'b10, 20);
        expect_val("allbust dealer", SEL_DEALER, 0, 0);
        expect_val("allbust last", SEL_LAST, 0, 5);
        expect_val("allbust res0", SEL_RESULT, 0, 2);
        expect_val("allbust res1", SEL_RESULT, 1, 2);
        check_all();
        next = 1'b1;
        @(negedge clock);
        next = 1'b0;
        @(negedge clock);
        expect_cleared("restart");
        check_all();

        // Simultaneous draw and next: stand wins, card discarded
        do_reset();
        press_draw(4'd4);
        card_in = 4'd9; draw = 1'b1; next = 1'b1;
        @(negedge clock);
        draw = 1'b0; next = 1'b0;
        repeat (2) @(negedge clock);
        expect_val("both score0", SEL_SCORE, 0, 4);
        expect_val("both last", SEL_LAST, 0, 4);
        expect_val("both active", SEL_ACTIVE, 0, 1);
        check_all();

        // Reset while the dealer is drawing
        do_reset();
        press_next();
        card_in = 4'd10; next = 1'b1;
        @(negedge clock);
        next = 1'b0;
        repeat (3) @(negedge clock);
        expect_val("mid phase", SEL_PHASE, 0, 1);
        expect_val("mid dealer", SEL_DEALER, 0, 10);
        check_all();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        expect_cleared("midreset");
        check_all();
        press_draw(4'd6);
        expect_val("midreset play", SEL_SCORE, 0, 6);
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
